// File: rtl/pipe_ctrl.sv
// Beta core pipeline control: bypass selects, load-use bubbles,
// data-memory wait sequencing with timeout, branch annul, stall counter.
module pipe_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rf_ra,
  input  logic [4:0]       rf_rb,
  input  logic             rf_ra_used,
  input  logic             rf_rb_used,
  input  logic [4:0]       alu_rc,
  input  logic             alu_we,
  input  logic             alu_is_ld,
  input  logic [4:0]       mem_rc,
  input  logic             mem_we,
  input  logic             mem_is_ld,
  input  logic [4:0]       wb_rc,
  input  logic             wb_we,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             br_taken,
  output logic             stall_if,
  output logic             stall_rf,
  output logic             stall_alu,
  output logic             stall_mem,
  output logic             annul_if,
  output logic             annul_rf,
  output logic             annul_mem,
  output logic [1:0]       byp_a_sel,
  output logic [1:0]       byp_b_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic mem_stall;
  logic err;
  logic a_alu, a_mem, a_wb;
  logic b_alu, b_mem, b_wb;
  logic lu_a, lu_b, load_use;
  logic [1:0] sel_a, sel_b;

  function automatic logic hit(
    input logic [4:0] r,
    input logic       used,
    input logic       we,
    input logic [4:0] rc
  );
    return used && we && (rc == r) && (r != 5'd31);
  endfunction

  assign a_alu = hit(rf_ra, rf_ra_used, alu_we, alu_rc);
  assign a_mem = hit(rf_ra, rf_ra_used, mem_we, mem_rc);
  assign a_wb  = hit(rf_ra, rf_ra_used, wb_we,  wb_rc);
  assign b_alu = hit(rf_rb, rf_rb_used, alu_we, alu_rc);
  assign b_mem = hit(rf_rb, rf_rb_used, mem_we, mem_rc);
  assign b_wb  = hit(rf_rb, rf_rb_used, wb_we,  wb_rc);

  assign lu_a = (a_alu && alu_is_ld) || (a_mem && mem_is_ld);
  assign lu_b = (b_alu && alu_is_ld) || (b_mem && mem_is_ld);
  assign load_use = lu_a || lu_b;

  // Youngest writer wins; a pending load there leaves the RF value.
  always_comb begin
    sel_a = 2'b00;
    if (a_alu)      sel_a = alu_is_ld ? 2'b00 : 2'b01;
    else if (a_mem) sel_a = mem_is_ld ? 2'b00 : 2'b10;
    else if (a_wb)  sel_a = 2'b11;
  end

  always_comb begin
    sel_b = 2'b00;
    if (b_alu)      sel_b = alu_is_ld ? 2'b00 : 2'b01;
    else if (b_mem) sel_b = mem_is_ld ? 2'b00 : 2'b10;
    else if (b_wb)  sel_b = 2'b11;
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_stall = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_req && !mem_ack) begin
          mem_stall = 1'b1;
          state_d   = S_WAIT;
          wcnt_d    = 16'd1;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = S_RUN;
          wcnt_d  = 16'd0;
        end else if (wcnt_q >= TMO) begin
          err     = 1'b1;
          state_d = S_RUN;
          wcnt_d  = 16'd0;
        end else begin
          mem_stall = 1'b1;
          wcnt_d    = wcnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_RUN;
        wcnt_d  = 16'd0;
      end
    endcase
  end

  // Memory stall holds the RF instruction rather than bubbling it.
  always_comb begin
    stall_if  = 1'b0;
    stall_rf  = 1'b0;
    stall_alu = 1'b0;
    stall_mem = 1'b0;
    annul_if  = 1'b0;
    annul_rf  = 1'b0;
    annul_mem = 1'b0;
    byp_a_sel = sel_a;
    byp_b_sel = sel_b;
    if (rst) begin
      annul_if  = 1'b1;
      annul_rf  = 1'b1;
      annul_mem = 1'b1;
      byp_a_sel = 2'b00;
      byp_b_sel = 2'b00;
    end else if (mem_stall) begin
      stall_if  = 1'b1;
      stall_rf  = 1'b1;
      stall_alu = 1'b1;
      stall_mem = 1'b1;
      annul_mem = 1'b1;
    end else if (load_use) begin
      stall_if = 1'b1;
      stall_rf = 1'b1;
      annul_rf = 1'b1;
    end else begin
      annul_if = br_taken;
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (stall_if && !(&scnt_q)) begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      wcnt_q  <= 16'd0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign mem_err   = err && !rst;
  assign stall_cnt = scnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage Beta core (IF, RF, ALU, MEM, WB).
- Computes operand bypass selects for the RF stage.
- Detects load-use hazards and inserts bubbles.
- Sequences multi-cycle data-memory accesses through a wait FSM with a timeout watchdog.
- Issues branch annuls and keeps a saturating stall counter.
- Its outputs drive the stage registers of the pipeline, write-back stage included.

Parameters:
CNT_W, 16, width of the stall performance counter.
MEM_TIMEOUT, 255, maximum number of wait cycles before mem_err is raised (1..2^16-1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
rf_ra  in  5  RF-stage operand A register.
rf_rb  in  5  RF-stage operand B register.
rf_ra_used  in  1  RF-stage instruction reads ra.
rf_rb_used  in  1  RF-stage instruction reads rb.
alu_rc  in  5  ALU-stage destination register.
alu_we  in  1  ALU-stage instruction writes rc.
alu_is_ld  in  1  ALU-stage instruction is LD/LDR.
mem_rc  in  5  MEM-stage destination register.
mem_we  in  1  MEM-stage instruction writes rc.
mem_is_ld  in  1  MEM-stage instruction is LD/LDR.
wb_rc  in  5  WB-stage destination register.
wb_we  in  1  WB-stage instruction writes rc.
mem_req  in  1  MEM stage is issuing a data-memory access.
mem_ack  in  1  data memory completes the access this cycle.
br_taken  in  1  RF-stage branch/JMP resolves taken.
stall_if  out  1  hold PC and the IF register.
stall_rf  out  1  hold the RF register.
stall_alu  out  1  hold the ALU register.
stall_mem  out  1  hold the MEM register.
annul_if  out  1  replace the IF-to-RF instruction with a NOP.
annul_rf  out  1  replace the RF-to-ALU instruction with a NOP (bubble).
annul_mem  out  1  replace the MEM-to-WB instruction with a NOP.
byp_a_sel  out  2  operand A source: 00 RF, 01 ALU, 10 MEM, 11 WB.
byp_b_sel  out  2  operand B source, same encoding.
mem_err  out  1  one-cycle pulse on memory timeout.
stall_cnt  out  CNT_W  number of cycles with stall_if high.

Behaviour:
Clocking and reset:
- Single clock clk; rst is asynchronous, active-high.
- While rst is high: FSM=RUN, wait counter=0, stall_cnt=0, mem_err=0.
- While rst is high, combinational outputs are forced: all stall_*=0, annul_if/annul_rf/annul_mem=1, byp_*=00.
- Reset mid-wait abandons the access; the FSM restarts in RUN.

Hazard match definition:
- Source register r matches a stage when that stage's we=1, its rc==r, and r!=31.
- Unused operands (rf_*_used=0) never match.

Bypass (combinational, per operand):
- Priority ALU > MEM > WB > RF.
- A loaded value is not bypassed from ALU or MEM; it is available only from WB.
- R31 always selects 00.

Load-use hazard (combinational):
- Condition: a used operand matches an ALU-stage or MEM-stage load.
- Response: stall_if=stall_rf=1, annul_rf=1.
- Repeats each cycle until the load reaches WB. Worst case is 2 bubbles.

Memory FSM, states RUN and WAIT:
- RUN, mem_req=1 and mem_ack=0: assert stall_if/rf/alu/mem=1 and annul_mem=1 this cycle; go to WAIT; wait counter=1.
- RUN, mem_req=1 and mem_ack=1: no stall.
- WAIT, mem_ack=0: all stalls and annul_mem stay high; wait counter increments.
- WAIT, mem_ack=1: stalls drop that same cycle; go to RUN.
- WAIT, wait counter==MEM_TIMEOUT with mem_ack=0: mem_err=1 for one cycle, stalls drop, go to RUN.
- mem_req is not re-sampled in WAIT.

Precedence: memory stall > load-use > branch.
- While any stall is active, br_taken is ignored; the branch re-evaluates when released.
- Otherwise br_taken=1 gives annul_if=1 for that cycle only.
- Memory stall and load-use in the same cycle: memory stall wins; annul_rf=0 so the RF instruction is held, not bubbled.

stall_cnt:
- Increments by 1 at each rising edge where stall_if=1.
- Saturates at all-ones and never wraps.

Test Plan:
- ADDC R1 in ALU, RF reads ra=R1 -> byp_a_sel=01. Same R1 also in MEM and WB -> still 01. ra=R31 with alu_rc=31 -> 00.
- LD into R2 in ALU, next instruction uses rb=R2 -> 2 cycles of stall_if=stall_rf=annul_rf=1, then byp_b_sel=11, stall_cnt=2.
- mem_req=1, mem_ack arriving 3 cycles later -> stalls high 3 cycles, low on the ack cycle, annul_mem high 3 cycles, FSM back in RUN.
- MEM_TIMEOUT=4, mem_req=1, mem_ack never asserted -> mem_err pulse in the 4th wait cycle, stalls released, next mem_req starts a new wait.
- br_taken=1 during a memory stall -> annul_if=0. br_taken=1 on the release cycle -> annul_if=1 for exactly 1 cycle.
- rst asserted mid-WAIT, asynchronously -> outputs forced to their reset values immediately, stall_cnt=0. After release, FSM in RUN and no stall without a new mem_req.
